bcrypt_eks_sequencer: RTL and testbench
=======================================

// Module: bcrypt_eks_sequencer
// PURPOSE
//  Control sequencer driving the bcrypt datapath through EksBlowfishSetup and the final ciphertext encryption.
//  Advances one step per completed Blowfish encryption; en_clk_2 pulses once per finished 16-round encrypt.
//  Per step, outputs which P-pair or S-box pair receives L/R, which half of the salt is XORed, and key vs. salt
//  selection for the P-array XOR. Signals completion of the 64x3 "OrpheanBeholderScryDoubt" encryption.
// PARAMETERS
//  COST_W      5    width of cost input
//  MIN_COST    4    cost values below this are executed as MIN_COST
//  NUM_PPAIRS  9    P-array pairs per ExpandKey (P0..P17)
//  SBOX_PAIRS  128  L/R pairs per S-box (256 words), 4 S-boxes
//  CT_ITERS    64   ciphertext encryption repetitions
//  CT_BLOCKS   3    64-bit ciphertext blocks per repetition
// PORTS
//  en_clk_2     in   1       clock: one rising edge per completed Blowfish encryption
//  reset_l      in   1       asynchronous, active-low reset
//  start        in   1       level; sampled in IDLE, launches a hash
//  cost         in   COST_W  log2 iteration count, held stable while busy
//  psel         out  9       one-hot P-pair write select (bit i -> P[2i],P[2i+1]); 0 when not writing P
//  sbox_wr      out  1       current result is written to S-box
//  sbox_sel     out  2       S-box index 0..3
//  sbox_addr    out  8       even word address (pair index * 2)
//  salt_half    out  1       0: XOR salt[63:0] into L/R, 1: salt[127:64]; only meaningful in EKS_SALT
//  salt_xor_en  out  1       salt XOR into L/R enabled (EKS_SALT only)
//  salt_key_sel out  1       1: P-array XORed with salt, 0: with key
//  pxor_req     out  1       P-array key/salt XOR required before next encryption (first step of each ExpandKey)
//  ct_blk       out  2       ciphertext block index 0..2 (CT_ENC only)
//  ct_last      out  1       final ciphertext repetition (iteration 63)
//  busy         out  1       high from accepted start until done
//  done         out  1       one-cycle pulse when final ciphertext encryption completes
// BEHAVIOUR
//  - Reset: state=IDLE; all counters 0; all outputs 0. Reset mid-operation aborts to IDLE with no done pulse.
//  - All outputs registered; update only on posedge en_clk_2.
//  - FSM: IDLE -> EKS_SALT -> {EXP_KEY -> EXP_SALT} x 2^cost_eff -> CT_ENC -> DONE -> IDLE.
//  - IDLE: start=1 -> latch cost_eff=max(cost,MIN_COST); enter EKS_SALT, step=0, pxor_req=1, salt_key_sel=0, busy=1.
//    start=0 -> stay. start while busy: ignored.
//  - ExpandKey phase (EKS_SALT/EXP_KEY/EXP_SALT): step counter 0..NUM_PPAIRS+4*SBOX_PAIRS-1 (0..520).
//    step 0..8: psel=1<<step, sbox_wr=0. step 9..520: psel=0, sbox_wr=1,
//    sbox_sel=(step-9)>>7, sbox_addr={(step-9)[6:0],1'b0}.
//    pxor_req=1 only at step 0. Phase ends at step 520 (wrap to 0, next state).
//  - EKS_SALT: salt_xor_en=1; salt_half toggles every step, starting at 0. salt_key_sel=0.
//  - EXP_KEY: salt_key_sel=0, salt_xor_en=0. EXP_SALT: salt_key_sel=1, salt_xor_en=0.
//  - Iteration counter: 32-bit, increments at end of each EXP_SALT. Equal to (1<<cost_eff)-1 at end -> CT_ENC,
//    otherwise -> EXP_KEY. cost_eff=31 yields 2^31 iterations with no overflow.
//  - CT_ENC: ct_blk cycles 0,1,2 per step; ct_iter 0..63 increments after blk 2. ct_last=1 when ct_iter==63.
//    After (iter 63, blk 2) -> DONE. psel=0, sbox_wr=0.
//  - DONE: done=1 for one cycle, busy=0, outputs cleared -> IDLE. A new start is sampled only in IDLE.
//  - Step counts at cost 4: 521 + 16*2*521 + 192 = 17385 en_clk_2 edges from start acceptance to done.
// STRUCTURE
//  - Package bcrypt_pkg: typedef enum eks_state_t {IDLE,EKS_SALT,EXP_KEY,EXP_SALT,CT_ENC,DONE};
//    localparams STEPS_PER_EXPAND=521, NUM_PPAIRS, SBOX_PAIRS, CT_ITERS, CT_BLOCKS, MIN_COST.
//  - Sub-module bcrypt_expand_step_ctr: 10-bit step counter decoding psel/sbox_wr/sbox_sel/sbox_addr/last_step,
//    shared by all three ExpandKey phases.
// TESTING
//  - Reset: hold reset_l=0, pulse clock -> all outputs 0, busy=0; deassert with start=0 -> stays IDLE.
//  - start, cost=4: step0 psel=9'h001 pxor_req=1; step8 psel=9'h100; step9 sbox_wr=1 sel=0 addr=0;
//    step520 sel=3 addr=8'hFE; salt_half toggles 0,1,0... throughout EKS_SALT.
//  - cost=4 full run: done pulses exactly at edge 17385; salt_key_sel=1 only within EXP_SALT; busy drops with done.
//  - cost=2 -> clamped: identical edge count (17385) as cost=4.
//  - CT_ENC: ct_blk sequence 0,1,2 repeated 64 times; ct_last high for final 3 steps only.
//  - Abort: reset_l low at step 300 of EXP_KEY -> immediate IDLE, no done; start with cost=5 -> full
//    run completes at 521+32*1042+192 = 34057 edges.

Source files
------------

// File: rtl/bcrypt_pkg.sv
// Shared types and constants for the bcrypt EKS sequencer.
// Holds the FSM state encoding, loop bounds and the cost clamp helper.
package bcrypt_pkg;

    localparam int COST_W           = 5;
    localparam int MIN_COST         = 4;
    localparam int NUM_PPAIRS       = 9;
    localparam int SBOX_PAIRS       = 128;
    localparam int CT_ITERS         = 64;
    localparam int CT_BLOCKS        = 3;
    localparam int STEPS_PER_EXPAND = NUM_PPAIRS + 4 * SBOX_PAIRS;

    typedef enum logic [2:0] {
        IDLE,
        EKS_SALT,
        EXP_KEY,
        EXP_SALT,
        CT_ENC,
        DONE
    } eks_state_t;

    function automatic logic [COST_W-1:0] clamp_cost(
        input logic [COST_W-1:0] c
    );
        return (c < COST_W'(MIN_COST)) ? COST_W'(MIN_COST) : c;
    endfunction

endpackage

// File: rtl/bcrypt_expand_step_ctr.sv
// ExpandKey step counter shared by the three ExpandKey phases.
// Walks P pairs first, then the four S-boxes, and flags the last step.
module bcrypt_expand_step_ctr
    import bcrypt_pkg::*;
(
    input  logic       en_clk_2,
    input  logic       reset_l,
    input  logic       en,
    output logic [9:0] step,
    output logic [8:0] psel,
    output logic       sbox_wr,
    output logic [1:0] sbox_sel,
    output logic [7:0] sbox_addr,
    output logic       last_step
);

    logic [9:0] sb_off;

    assign sb_off    = step - 10'(NUM_PPAIRS);
    assign last_step = en && (step == 10'(STEPS_PER_EXPAND - 1));

    // Step register: counts while enabled, wraps at phase end, parks at 0.
    always_ff @(posedge en_clk_2 or negedge reset_l) begin
        if (!reset_l) begin
            step <= '0;
        end else if (en && !last_step) begin
            step <= step + 10'd1;
        end else begin
            step <= '0;
        end
    end

    // Decode the step into a P-pair select or an S-box pair address.
    always_comb begin
        psel      = '0;
        sbox_wr   = 1'b0;
        sbox_sel  = '0;
        sbox_addr = '0;
        if (en) begin
            if (step < 10'(NUM_PPAIRS)) begin
                psel = 9'd1 << step[3:0];
            end else begin
                sbox_wr   = 1'b1;
                sbox_sel  = sb_off[8:7];
                sbox_addr = {sb_off[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/bcrypt_eks_sequencer.sv
// Sequencer for EksBlowfishSetup plus the final ciphertext loop.
// Advances one step per completed Blowfish encryption edge.
module bcrypt_eks_sequencer
    import bcrypt_pkg::*;
(
    input  logic              en_clk_2,
    input  logic              reset_l,
    input  logic              start,
    input  logic [COST_W-1:0] cost,
    output logic [8:0]        psel,
    output logic              sbox_wr,
    output logic [1:0]        sbox_sel,
    output logic [7:0]        sbox_addr,
    output logic              salt_half,
    output logic              salt_xor_en,
    output logic              salt_key_sel,
    output logic              pxor_req,
    output logic [1:0]        ct_blk,
    output logic              ct_last,
    output logic              busy,
    output logic              done
);

    eks_state_t        state, nstate;
    logic [COST_W-1:0] cost_eff, n_cost;
    logic [31:0]       iter, n_iter;
    logic [31:0]       target;
    logic [1:0]        blk, n_blk;
    logic [5:0]        ct_iter, n_ctit;
    logic              expand_en;
    logic              last_step;
    logic [9:0]        step;

    assign expand_en = (state == EKS_SALT) ||
                       (state == EXP_KEY)  ||
                       (state == EXP_SALT);
    assign target    = (32'd1 << cost_eff) - 32'd1;

    bcrypt_expand_step_ctr u_step (
        .en_clk_2  (en_clk_2),
        .reset_l   (reset_l),
        .en        (expand_en),
        .step      (step),
        .psel      (psel),
        .sbox_wr   (sbox_wr),
        .sbox_sel  (sbox_sel),
        .sbox_addr (sbox_addr),
        .last_step (last_step)
    );

    // State and loop counters, cleared asynchronously on abort.
    always_ff @(posedge en_clk_2 or negedge reset_l) begin
        if (!reset_l) begin
            state    <= IDLE;
            cost_eff <= '0;
            iter     <= '0;
            blk      <= '0;
            ct_iter  <= '0;
        end else begin
            state    <= nstate;
            cost_eff <= n_cost;
            iter     <= n_iter;
            blk      <= n_blk;
            ct_iter  <= n_ctit;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        nstate = state;
        n_cost = cost_eff;
        n_iter = iter;
        n_blk  = blk;
        n_ctit = ct_iter;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nstate = EKS_SALT;
                    n_cost = clamp_cost(cost);
                    n_iter = '0;
                    n_blk  = '0;
                    n_ctit = '0;
                end
            end
            EKS_SALT: begin
                if (last_step) nstate = EXP_KEY;
            end
            EXP_KEY: begin
                if (last_step) nstate = EXP_SALT;
            end
            EXP_SALT: begin
                if (last_step) begin
                    n_iter = iter + 32'd1;
                    nstate = (iter == target) ? CT_ENC : EXP_KEY;
                end
            end
            CT_ENC: begin
                if (blk == 2'(CT_BLOCKS - 1)) begin
                    n_blk = '0;
                    if (ct_iter == 6'(CT_ITERS - 1)) nstate = DONE;
                    else n_ctit = ct_iter + 6'd1;
                end else begin
                    n_blk = blk + 2'd1;
                end
            end
            DONE: begin
                nstate = IDLE;
                n_iter = '0;
                n_blk  = '0;
                n_ctit = '0;
            end
            default: nstate = IDLE;
        endcase
    end

    // Per-step control outputs decoded from registered state only.
    always_comb begin
        salt_xor_en  = (state == EKS_SALT);
        salt_half    = (state == EKS_SALT) && step[0];
        salt_key_sel = (state == EXP_SALT);
        pxor_req     = expand_en && (step == 10'd0);
        ct_blk       = (state == CT_ENC) ? blk : 2'd0;
        ct_last      = (state == CT_ENC) &&
                       (ct_iter == 6'(CT_ITERS - 1));
        busy         = expand_en || (state == CT_ENC);
        done         = (state == DONE);
    end

endmodule

// File: tb/tb_bcrypt_eks_sequencer.sv
// Self-checking bench for bcrypt_eks_sequencer.
// Expected per-edge output vectors are queued at start and popped per edge.
module tb_bcrypt_eks_sequencer;

    logic       en_clk_2 = 1'b0;
    logic       reset_l  = 1'b0;
    logic       start    = 1'b0;
    logic [4:0] cost     = '0;

    logic [8:0] psel;
    logic       sbox_wr;
    logic [1:0] sbox_sel;
    logic [7:0] sbox_addr;
    logic       salt_half;
    logic       salt_xor_en;
    logic       salt_key_sel;
    logic       pxor_req;
    logic [1:0] ct_blk;
    logic       ct_last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    logic [28:0] sb[$];

    bcrypt_eks_sequencer dut (
        .en_clk_2     (en_clk_2),
        .reset_l      (reset_l),
        .start        (start),
        .cost         (cost),
        .psel         (psel),
        .sbox_wr      (sbox_wr),
        .sbox_sel     (sbox_sel),
        .sbox_addr    (sbox_addr),
        .salt_half    (salt_half),
        .salt_xor_en  (salt_xor_en),
        .salt_key_sel (salt_key_sel),
        .pxor_req     (pxor_req),
        .ct_blk       (ct_blk),
        .ct_last      (ct_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 en_clk_2 = ~en_clk_2;

    function automatic logic [28:0] obs_vec();
        return {psel, sbox_wr, sbox_sel, sbox_addr, salt_half,
                salt_xor_en, salt_key_sel, pxor_req, ct_blk,
                ct_last, busy, done};
    endfunction

    // Outputs expected after edge k (k=0 is the start-accepting edge).
    function automatic logic [28:0] exp_vec(input int ce, input int k);
        int n, e, ph, s, c;
        logic [8:0] ps;
        logic sw, sh, sx, sk, px, lst, bz, dn;
        logic [1:0] sel, blk;
        logic [7:0] addr;
        n = 1 << ce;
        e = 521 * (1 + 2 * n);
        ps = '0; sw = 0; sel = '0; addr = '0; sh = 0; sx = 0;
        sk = 0; px = 0; blk = '0; lst = 0; bz = 0; dn = 0;
        if (k < e) begin
            ph = k / 521;
            s  = k % 521;
            bz = 1;
            px = (s == 0);
            if (s < 9) begin
                ps = 9'd1 << s;
            end else begin
                sw   = 1;
                sel  = 2'((s - 9) / 128);
                addr = 8'(((s - 9) % 128) * 2);
            end
            if (ph == 0) begin
                sx = 1;
                sh = (s % 2) == 1;
            end else if (ph % 2 == 0) begin
                sk = 1;
            end
        end else if (k < e + 192) begin
            c   = k - e;
            blk = 2'(c % 3);
            lst = (c / 3) == 63;
            bz  = 1;
        end else if (k == e + 192) begin
            dn = 1;
        end
        return {ps, sw, sel, addr, sh, sx, sk, px, blk, lst, bz, dn};
    endfunction

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic run_hash(input int cst, input int stop_k,
                            output int done_edge,
                            output int last_cnt);
        int ce, e, last_k;
        logic [28:0] ev;
        ce = (cst < 4) ? 4 : cst;
        e = 521 * (1 + 2 * (1 << ce));
        last_k = (stop_k >= 0) ? stop_k : e + 193;
        done_edge = -1;
        last_cnt = 0;
        @(negedge en_clk_2);
        cost  = 5'(cst);
        start = 1'b1;
        for (int k = 0; k <= last_k; k++) sb.push_back(exp_vec(ce, k));
        for (int k = 0; k <= last_k; k++) begin
            @(negedge en_clk_2);
            if (k == 0) start = 1'b0;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL queue_empty observed=0 expected=1");
            end else begin
                ev = sb.pop_front();
                chk($sformatf("edge%0d", k), 64'(obs_vec()), 64'(ev));
            end
            if (done && done_edge < 0) done_edge = k;
            if (ct_last) last_cnt++;
        end
    endtask

    int de, lc;

    initial begin
        // Reset held: outputs must be quiet.
        repeat (2) @(posedge en_clk_2);
        #1;
        chk("reset_outputs", 64'(obs_vec()), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge en_clk_2);
        reset_l = 1'b1;
        start   = 1'b0;
        repeat (3) @(negedge en_clk_2);
        chk("idle_no_start", 64'(obs_vec()), 64'd0);

        // Full cost-4 run.
        run_hash(4, -1, de, lc);
        chk("cost4_done_edge", 64'(de), 64'd17385);
        chk("cost4_ct_last_cnt", 64'(lc), 64'd3);

        // Cost 2 clamps to 4.
        run_hash(2, -1, de, lc);
        chk("cost2_done_edge", 64'(de), 64'd17385);

        // Abort at step 300 of the first EXP_KEY.
        run_hash(4, 821, de, lc);
        chk("abort_no_done", 64'(de), -64'sd1);
        reset_l = 1'b0;
        #1;
        chk("abort_outputs", 64'(obs_vec()), 64'd0);
        sb.delete();
        @(negedge en_clk_2);
        reset_l = 1'b1;
        repeat (2) @(negedge en_clk_2);
        chk("abort_idle", 64'(obs_vec()), 64'd0);

        // Full cost-5 run after abort.
        run_hash(5, -1, de, lc);
        chk("cost5_done_edge", 64'(de), 64'd34057);
        chk("cost5_queue_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
